// File: rtl/parking_pkg.sv
// Shared parking-lot definitions: lot size, field widths, exit FSM encoding and fee arithmetic.
// Used by both the entry-side allocator and the exit controller.
package parking_pkg;

    localparam int NUM_SPOTS = 4;
    localparam int TIMER_W   = 8;
    localparam int FEE_W     = 10;

    localparam logic [TIMER_W-1:0] TIMER_MAX = '1;
    localparam logic [FEE_W-1:0]   FEE_MAX   = '1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_PAY,
        GATE_OPEN,
        RELEASE
    } exit_state_t;

    // Elapsed ticks times rate, clamped to the largest representable fee.
    function automatic logic [FEE_W-1:0] calc_fee(input logic [TIMER_W-1:0] ticks, input int rate);
        int product;
        product = int'(ticks) * rate;
        return (product > int'(FEE_MAX)) ? FEE_MAX : FEE_W'(product);
    endfunction

endpackage

// File: rtl/spot_timer.sv
// Per-spot parking timer: counts billing ticks while the spot is occupied and saturates at TIMER_MAX.
module spot_timer
    import parking_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               enable,
    input  logic               tick,
    output logic [TIMER_W-1:0] count
);

    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && tick && (count != TIMER_MAX)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/parking_exit_controller.sv
// Exit-side controller: tracks occupancy and per-spot time, bills an exiting car,
// waits for payment, opens the gate, then frees the spot.
module parking_exit_controller
    import parking_pkg::*;
#(
    parameter int NUM_SPOTS   = parking_pkg::NUM_SPOTS,
    parameter int RATE        = 2,
    parameter int GATE_CYCLES = 8,
    parameter int PAY_TIMEOUT = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_SPOTS-1:0]         entry_onehot,
    input  logic                         tick,
    input  logic                         exit_req,
    input  logic [$clog2(NUM_SPOTS)-1:0] exit_spot,
    input  logic                         pay_ok,
    output logic [NUM_SPOTS-1:0]         occupied,
    output logic [FEE_W-1:0]             fee,
    output logic                         fee_valid,
    output logic                         gate_open,
    output logic [NUM_SPOTS-1:0]         release_onehot,
    output logic                         exit_error,
    output logic                         busy
);

    localparam int SPOT_W  = $clog2(NUM_SPOTS);
    localparam int CNT_MAX = (PAY_TIMEOUT > GATE_CYCLES) ? PAY_TIMEOUT : GATE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] PAY_LAST  = CNT_W'(PAY_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] GATE_LAST = CNT_W'(GATE_CYCLES - 1);

    exit_state_t          state, state_next;
    logic [CNT_W-1:0]     cnt;
    logic [SPOT_W-1:0]    spot_q;
    logic [TIMER_W-1:0]   timer [NUM_SPOTS];
    logic [NUM_SPOTS-1:0] entry_accept;
    logic [NUM_SPOTS-1:0] release_vec;
    logic                 exit_accept;
    logic                 exit_reject;
    logic                 pay_abort;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_next  = state;
        exit_accept = 1'b0;
        exit_reject = 1'b0;
        pay_abort   = 1'b0;
        case (state)
            IDLE: begin
                if (exit_req) begin
                    if (occupied[exit_spot]) begin
                        exit_accept = 1'b1;
                        state_next  = WAIT_PAY;
                    end else begin
                        exit_reject = 1'b1;
                    end
                end
            end
            WAIT_PAY: begin
                if (pay_ok) begin
                    state_next = GATE_OPEN;
                end else if (cnt == PAY_LAST) begin
                    pay_abort  = 1'b1;
                    state_next = IDLE;
                end
            end
            GATE_OPEN: if (cnt == GATE_LAST) state_next = RELEASE;
            RELEASE:   state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // cnt measures time spent in the current state; it restarts on every transition.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            spot_q     <= '0;
            fee        <= '0;
            exit_error <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= (state_next != state || state == IDLE) ? '0 : cnt + 1'b1;
            exit_error <= exit_reject | pay_abort;
            if (exit_accept) begin
                spot_q <= exit_spot;
                fee    <= calc_fee(timer[exit_spot], RATE);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_SPOTS; i++) begin
            release_vec[i] = (state == RELEASE) && (spot_q == SPOT_W'(i));
        end
    end

    assign fee_valid      = (state == WAIT_PAY);
    assign gate_open      = (state == GATE_OPEN);
    assign busy           = (state != IDLE);
    assign release_onehot = release_vec;

    // A release wins over an entry aimed at the same spot; entries to occupied spots are dropped.
    assign entry_accept = entry_onehot & ~occupied & ~release_vec;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occupied <= '0;
        end else begin
            occupied <= (occupied | entry_accept) & ~release_vec;
        end
    end

    for (genvar i = 0; i < NUM_SPOTS; i++) begin : g_timer
        spot_timer u_timer (
            .clk    (clk),
            .reset  (reset),
            .clear  (entry_accept[i] | release_vec[i]),
            .enable (occupied[i]),
            .tick   (tick),
            .count  (timer[i])
        );
    end

endmodule

// File: tb/tb_parking_exit_controller.sv
// Self-checking bench: directed scenarios plus randomized traffic against an occupancy/tick-count model.
module tb_parking_exit_controller;

    localparam int GATE = 8;
    localparam int TMO  = 64;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] entry_onehot;
    logic       tick;
    logic       exit_req;
    logic [1:0] exit_spot;
    logic       pay_ok;

    logic [3:0] occ_a, rel_a, occ_b, rel_b;
    logic [9:0] fee_a, fee_b;
    logic       fv_a, gate_a, err_a, busy_a;
    logic       fv_b, gate_b, err_b, busy_b;
    logic [7:0] st_a, st_b;

    assign st_a = {busy_a, fv_a, gate_a, err_a, rel_a};
    assign st_b = {busy_b, fv_b, gate_b, err_b, rel_b};

    int checks = 0;
    int errors = 0;

    // Reference model: occupancy flag and raw (unsaturated) tick count per spot.
    int m_occ   [4];
    int m_ticks [4];

    always #5 clk = ~clk;

    parking_exit_controller #(.RATE(2)) dut (
        .clk(clk), .reset(reset), .entry_onehot(entry_onehot), .tick(tick),
        .exit_req(exit_req), .exit_spot(exit_spot), .pay_ok(pay_ok),
        .occupied(occ_a), .fee(fee_a), .fee_valid(fv_a), .gate_open(gate_a),
        .release_onehot(rel_a), .exit_error(err_a), .busy(busy_a)
    );

    parking_exit_controller #(.RATE(5)) dut5 (
        .clk(clk), .reset(reset), .entry_onehot(entry_onehot), .tick(tick),
        .exit_req(exit_req), .exit_spot(exit_spot), .pay_ok(pay_ok),
        .occupied(occ_b), .fee(fee_b), .fee_valid(fv_b), .gate_open(gate_b),
        .release_onehot(rel_b), .exit_error(err_b), .busy(busy_b)
    );

    function automatic logic [3:0] model_occ();
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = (m_occ[i] != 0);
        return v;
    endfunction

    function automatic logic [9:0] exp_fee(input logic [1:0] spot, input int rate);
        int t;
        int f;
        t = (m_ticks[spot] > 255) ? 255 : m_ticks[spot];
        f = t * rate;
        return (f > 1023) ? 10'd1023 : 10'(f);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            m_occ[i]   = 0;
            m_ticks[i] = 0;
        end
    endtask

    task automatic model_step(input logic [3:0] e, input logic t, input int rel);
        for (int i = 0; i < 4; i++) begin
            if (i == rel) begin
                m_occ[i]   = 0;
                m_ticks[i] = 0;
            end else if (e[i] && m_occ[i] == 0) begin
                m_occ[i]   = 1;
                m_ticks[i] = 0;
            end else if (t && m_occ[i] != 0) begin
                m_ticks[i]++;
            end
        end
    endtask

    // Drive one cycle of inputs, advance the model, sample 1 time unit after the edge.
    task automatic cyc(input logic [3:0] e, input logic t, input logic xr, input logic [1:0] xs,
                       input logic p, input int rel);
        entry_onehot = e;
        tick         = t;
        exit_req     = xr;
        exit_spot    = xs;
        pay_ok       = p;
        model_step(e, t, rel);
        @(posedge clk);
        #1;
        entry_onehot = '0;
        tick         = 1'b0;
        exit_req     = 1'b0;
        pay_ok       = 1'b0;
    endtask

    task automatic side(input bit rnd, output logic [3:0] e, output logic t);
        e = 4'b0000;
        t = 1'b0;
        if (rnd) begin
            if ($urandom_range(0, 3) == 0) e = 4'b0001 << $urandom_range(0, 3);
            t = 1'($urandom_range(0, 1));
        end
    endtask

    // Complete exit transaction; pay_delay < 0 means never pay.
    task automatic exit_flow(input logic [1:0] spot, input int pay_delay, input bit rnd);
        logic [3:0] e;
        logic       t;
        logic       xr;
        logic [7:0] exp_st;
        logic [9:0] f2, f5;
        logic [3:0] oh;
        bit         accept;
        oh     = 4'b0001 << spot;
        accept = (m_occ[spot] != 0);
        f2     = exp_fee(spot, 2);
        f5     = exp_fee(spot, 5);
        side(rnd, e, t);
        cyc(e, t, 1'b1, spot, 1'b0, -1);
        if (!accept) begin
            exp_st = 8'b0001_0000;
            checks++;
            if (st_a !== exp_st || st_b !== exp_st) begin
                errors++;
                $display("FAIL reject spot%0d: status a=%b b=%b expected %b", spot, st_a, st_b, exp_st);
            end
            side(rnd, e, t);
            cyc(e, t, 1'b0, 2'd0, 1'b0, -1);
            checks++;
            if (st_a !== 8'h00 || st_b !== 8'h00) begin
                errors++;
                $display("FAIL reject_clear: status a=%b b=%b expected 00000000", st_a, st_b);
            end
            return;
        end
        exp_st = 8'b1100_0000;
        checks++;
        if (st_a !== exp_st || st_b !== exp_st) begin
            errors++;
            $display("FAIL accept spot%0d: status a=%b b=%b expected %b", spot, st_a, st_b, exp_st);
        end
        checks++;
        if (fee_a !== f2 || fee_b !== f5) begin
            errors++;
            $display("FAIL fee spot%0d: got %0d/%0d expected %0d/%0d", spot, fee_a, fee_b, f2, f5);
        end
        if (pay_delay < 0) begin
            for (int k = 1; k < TMO; k++) begin
                side(rnd, e, t);
                xr = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
                cyc(e, t, xr, 2'($urandom_range(0, 3)), 1'b0, -1);
                checks++;
                if (st_a !== exp_st || st_b !== exp_st || fee_a !== f2 || fee_b !== f5) begin
                    errors++;
                    $display("FAIL wait_hold k=%0d: status %b fee %0d/%0d expected %b fee %0d/%0d",
                             k, st_a, fee_a, fee_b, exp_st, f2, f5);
                end
            end
            side(rnd, e, t);
            cyc(e, t, 1'b0, 2'd0, 1'b0, -1);
            checks++;
            if (st_a !== 8'b0001_0000 || st_b !== 8'b0001_0000 ||
                occ_a !== model_occ() || occ_b !== model_occ()) begin
                errors++;
                $display("FAIL timeout: status a=%b b=%b occ=%b expected 00010000 occ=%b",
                         st_a, st_b, occ_a, model_occ());
            end
            side(rnd, e, t);
            cyc(e, t, 1'b0, 2'd0, 1'b0, -1);
            checks++;
            if (st_a !== 8'h00 || st_b !== 8'h00) begin
                errors++;
                $display("FAIL timeout_clear: status a=%b b=%b expected 00000000", st_a, st_b);
            end
            return;
        end
        for (int k = 0; k < pay_delay; k++) begin
            side(rnd, e, t);
            xr = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            cyc(e, t, xr, 2'($urandom_range(0, 3)), 1'b0, -1);
            checks++;
            if (st_a !== exp_st || fee_a !== f2 || fee_b !== f5) begin
                errors++;
                $display("FAIL fee_frozen k=%0d: status %b fee %0d/%0d expected %b fee %0d/%0d",
                         k, st_a, fee_a, fee_b, exp_st, f2, f5);
            end
        end
        side(rnd, e, t);
        cyc(e, t, 1'b0, 2'd0, 1'b1, -1);
        for (int g = 1; g <= GATE; g++) begin
            if (g > 1) begin
                side(rnd, e, t);
                xr = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
                cyc(e, t, xr, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), -1);
            end
            checks++;
            if (st_a !== 8'b1010_0000 || st_b !== 8'b1010_0000) begin
                errors++;
                $display("FAIL gate_open g=%0d: status a=%b b=%b expected 10100000", g, st_a, st_b);
            end
        end
        side(rnd, e, t);
        cyc(e, t, 1'b0, 2'd0, 1'b0, -1);
        exp_st = {4'b1000, oh};
        checks++;
        if (st_a !== exp_st || st_b !== exp_st || occ_a !== model_occ()) begin
            errors++;
            $display("FAIL release spot%0d: status a=%b b=%b occ=%b expected %b occ=%b",
                     spot, st_a, st_b, occ_a, exp_st, model_occ());
        end
        side(rnd, e, t);
        cyc(e | oh, t, 1'b0, 2'd0, 1'b0, int'(spot));
        checks++;
        if (st_a !== 8'h00 || st_b !== 8'h00 || occ_a !== model_occ() || occ_b !== model_occ()) begin
            errors++;
            $display("FAIL after_release spot%0d: status a=%b occ=%b/%b expected 00000000 occ=%b",
                     spot, st_a, occ_a, occ_b, model_occ());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (st_a !== 8'h00 || st_b !== 8'h00 || occ_a !== 4'h0 || occ_b !== 4'h0 ||
            fee_a !== 10'd0 || fee_b !== 10'd0) begin
            errors++;
            $display("FAIL reset_hold: status %b occ %b fee %0d expected all zero", st_a, occ_a, fee_a);
        end
        reset = 1'b0;
        model_clear();
        cyc(4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, -1);
        checks++;
        if (st_a !== 8'h00 || occ_a !== 4'h0 || occ_b !== 4'h0) begin
            errors++;
            $display("FAIL reset_release: status %b occ %b expected zero", st_a, occ_a);
        end
    endtask

    task automatic test_basic_fee();
        cyc(4'b0001, 1'b0, 1'b0, 2'd0, 1'b0, -1);
        repeat (5) cyc(4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, -1);
        exit_flow(2'd0, 0, 1'b0);
    endtask

    task automatic test_error_exit();
        cyc(4'b0001, 1'b0, 1'b0, 2'd0, 1'b0, -1);
        exit_flow(2'd2, 0, 1'b0);
        exit_flow(2'd0, 0, 1'b0);
    endtask

    task automatic test_timeout();
        cyc(4'b1000, 1'b0, 1'b0, 2'd0, 1'b0, -1);
        repeat (3) cyc(4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, -1);
        exit_flow(2'd3, -1, 1'b0);
        exit_flow(2'd3, 3, 1'b0);
    endtask

    task automatic test_concurrent_entry();
        cyc(4'b0001, 1'b0, 1'b0, 2'd0, 1'b0, -1);
        repeat (3) cyc(4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, -1);
        cyc(4'b0101, 1'b1, 1'b0, 2'd0, 1'b0, -1);
        repeat (2) cyc(4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, -1);
        exit_flow(2'd0, 2, 1'b0);
        exit_flow(2'd2, 1, 1'b0);
    endtask

    task automatic test_saturation();
        cyc(4'b0010, 1'b0, 1'b0, 2'd0, 1'b0, -1);
        repeat (300) cyc(4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, -1);
        exit_flow(2'd1, 0, 1'b0);
    endtask

    task automatic test_reset_gate_open();
        cyc(4'b0100, 1'b0, 1'b0, 2'd0, 1'b0, -1);
        repeat (4) cyc(4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, -1);
        cyc(4'b0000, 1'b0, 1'b1, 2'd2, 1'b0, -1);
        cyc(4'b0000, 1'b0, 1'b0, 2'd0, 1'b1, -1);
        repeat (3) cyc(4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, -1);
        checks++;
        if (gate_a !== 1'b1 || occ_a !== 4'b0100) begin
            errors++;
            $display("FAIL pre_reset_gate: gate=%b occ=%b expected 1 occ=0100", gate_a, occ_a);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (st_a !== 8'h00 || st_b !== 8'h00 || occ_a !== 4'h0 || fee_a !== 10'd0 || fee_b !== 10'd0) begin
            errors++;
            $display("FAIL mid_gate_reset: status %b occ %b fee %0d expected all zero", st_a, occ_a, fee_a);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
        for (int k = 0; k < 12; k++) begin
            cyc(4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, -1);
            checks++;
            if (st_a !== 8'h00 || occ_a !== 4'h0) begin
                errors++;
                $display("FAIL post_reset k=%0d: status %b occ %b expected zero", k, st_a, occ_a);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] e;
        logic       t;
        int         delay;
        for (int it = 0; it < 40; it++) begin
            repeat ($urandom_range(0, 15)) begin
                side(1'b1, e, t);
                cyc(e, t, 1'b0, 2'd0, 1'b0, -1);
            end
            delay = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, 20));
            exit_flow(2'($urandom_range(0, 3)), delay, 1'b1);
        end
    endtask

    initial begin
        reset        = 1'b1;
        entry_onehot = '0;
        tick         = 1'b0;
        exit_req     = 1'b0;
        exit_spot    = '0;
        pay_ok       = 1'b0;
        model_clear();
        test_reset();
        test_basic_fee();
        test_error_exit();
        test_timeout();
        test_concurrent_entry();
        test_saturation();
        test_reset_gate_open();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
